// File: rtl/uart_pkg.sv
// Shared definitions for the UART serial blocks: FSM encoding, line levels,
// default frame geometry and counter sizing.
package uart_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StStart = 2'd1,
    StData  = 2'd2,
    StStop  = 2'd3
  } uart_state_e;

  localparam logic UartIdleLevel = 1'b1;
  localparam logic StartBit      = 1'b0;

  localparam int unsigned DefaultClksPerBit = 8;
  localparam int unsigned DefaultDataW      = 8;

  // Baud counter width; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned clks);
    return (clks <= 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Word handshake and serial-line bundle of the UART transmitter.
interface uart_tx_serializer_if import uart_pkg::*; #(
  parameter int unsigned DataW = DefaultDataW
);
  logic             tx_valid;
  logic [DataW-1:0] tx_data;
  logic             tx_ready;
  logic             tx_serial;
  logic             tx_busy;
  logic             tx_done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_serial, tx_busy, tx_done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_serial, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Modulo-ClksPerBit counter with synchronous clear; tick_o marks the last
// cycle of each serial bit period.
module uart_baud_tick import uart_pkg::*; #(
  parameter int unsigned ClksPerBit = DefaultClksPerBit,
  localparam int unsigned CntW      = cnt_width(ClksPerBit)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear_i,
  input  logic            en_i,
  output logic [CntW-1:0] count_o,
  output logic            tick_o
);

  localparam logic [CntW-1:0] CntMax = CntW'(ClksPerBit - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o  = en_i && (cnt_q == CntMax);
  assign count_o = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: accepts a word on a valid/ready handshake and shifts out
// start bit, DataW data bits LSB first, then a stop bit.
module uart_tx_serializer import uart_pkg::*; #(
  parameter int unsigned ClksPerBit = DefaultClksPerBit,
  parameter int unsigned DataW      = DefaultDataW
) (
  input logic                 clk,
  input logic                 rst,
  uart_tx_serializer_if.slave tx
);

  localparam int unsigned CntW = cnt_width(ClksPerBit);
  localparam int unsigned IdxW = $clog2(DataW + 1);
  // done_q is registered, so it is set one cycle before the final stop cycle.
  localparam logic [CntW-1:0] DoneCnt = CntW'(ClksPerBit - 2);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DataW - 1);

  uart_state_e      state_q, state_d;
  logic [DataW-1:0] shift_q, shift_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             accept;
  logic             tick;
  logic             baud_en;
  logic [CntW-1:0]  baud_cnt;

  assign tx.tx_ready  = (state_q == StIdle);
  assign tx.tx_serial = serial_q;
  assign tx.tx_busy   = busy_q;
  assign tx.tx_done   = done_q;

  assign accept  = tx.tx_valid && tx.tx_ready;
  assign baud_en = (state_q != StIdle);

  uart_baud_tick #(
    .ClksPerBit(ClksPerBit)
  ) u_baud_tick (
    .clk     (clk),
    .rst     (rst),
    .clear_i (accept),
    .en_i    (baud_en),
    .count_o (baud_cnt),
    .tick_o  (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      shift_q  <= '0;
      idx_q    <= '0;
      serial_q <= UartIdleLevel;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      idx_q    <= idx_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          shift_d = tx.tx_data;
          idx_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (tick) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (idx_q == LastIdx) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered, so they are decoded from the next state.
  always_comb begin
    serial_d = UartIdleLevel;
    case (state_d)
      StStart: serial_d = StartBit;
      StData:  serial_d = shift_d[0];
      default: serial_d = UartIdleLevel;
    endcase
    busy_d = (state_d != StIdle);
    done_d = (state_q == StStop) && (baud_cnt == DoneCnt);
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: frame tables, hand-written
// corner sequences and a scoreboarded loopback receiver.
module tb_uart_tx_serializer;
  import uart_pkg::*;

  localparam int Cpb      = 4;
  localparam int DataW    = 8;
  localparam int FrameCyc = (DataW + 2) * Cpb;

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // line level per bit period, bit 0 = start bit
    logic       noise;  // poke tx_valid/tx_data while busy
  } frame_vec_t;

  logic clk = 1'b0;
  logic rst;

  uart_tx_serializer_if #(.DataW(DataW)) tx_if ();

  uart_tx_serializer #(
    .ClksPerBit (Cpb),
    .DataW      (DataW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .tx  (tx_if)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  logic       rx_en = 1'b0;
  logic       rx_active = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_word = '0;
  logic [7:0] exp_w;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference receiver: samples each bit in the middle of its period.
  always @(negedge clk) begin
    if (tx_if.tx_done === 1'b1) done_cnt++;
    if (!rx_en) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx_if.tx_serial === 1'b0) begin
        rx_active = 1'b1;
        rx_cnt    = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt >= Cpb && rx_cnt < (DataW + 1) * Cpb && (rx_cnt % Cpb) == Cpb / 2) begin
        rx_word[(rx_cnt / Cpb) - 1] = tx_if.tx_serial;
      end else if (rx_cnt == (DataW + 1) * Cpb + Cpb / 2) begin
        check("rx_stop_bit", 32'(tx_if.tx_serial), 32'd1);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rx_unexpected_frame: got %0h expected no frame", rx_word);
        end else begin
          exp_w = exp_q.pop_front();
          check("rx_word", 32'(rx_word), 32'(exp_w));
        end
        rx_active = 1'b0;
      end
    end
  end

  // Called and returns at a negedge with the DUT idle.
  task automatic run_frame(input frame_vec_t v);
    int d0;
    d0 = done_cnt;
    check("pre_ready", 32'(tx_if.tx_ready), 32'd1);
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = v.data;
    exp_q.push_back(v.data);
    for (int c = 1; c <= FrameCyc; c++) begin
      @(negedge clk);
      if (c == 1) tx_if.tx_valid = 1'b0;
      if (v.noise && c == 10) begin
        tx_if.tx_valid = 1'b1;
        tx_if.tx_data  = 8'h3C;
      end
      if (v.noise && c == 11) tx_if.tx_valid = 1'b0;
      if (v.noise && c > 11) tx_if.tx_data = 8'($urandom);
      check("frame_serial", 32'(tx_if.tx_serial), 32'(v.line[(c - 1) / Cpb]));
      check("frame_ready_busy", 32'({tx_if.tx_ready, tx_if.tx_busy}), 32'b01);
      check("frame_done", 32'(tx_if.tx_done), 32'(c == FrameCyc));
    end
    @(negedge clk);
    check("post_ready_busy", 32'({tx_if.tx_ready, tx_if.tx_busy}), 32'b10);
    check("post_serial_done", 32'({tx_if.tx_serial, tx_if.tx_done}), 32'b10);
    if (v.noise) begin
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        check("noise_idle", 32'({tx_if.tx_serial, tx_if.tx_busy}), 32'b10);
      end
    end
    check("frame_done_count", 32'(done_cnt - d0), 32'd1);
  endtask

  task automatic send_word(input logic [7:0] d);
    int waited;
    waited = 0;
    while (tx_if.tx_ready !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 100) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_word_ready_timeout: got ready=%0b expected 1", tx_if.tx_ready);
    end
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = d;
    exp_q.push_back(d);
    @(negedge clk);
    tx_if.tx_valid = 1'b0;
  endtask

  frame_vec_t vecs[4];
  frame_vec_t after_rst;

  initial begin
    int acc, first_done, second_done, run, gap, d0, waited;

    vecs[0]   = '{8'hA5, 10'b1_10100101_0, 1'b0};
    vecs[1]   = '{8'h5A, 10'b1_01011010_0, 1'b0};
    vecs[2]   = '{8'h81, 10'b1_10000001_0, 1'b1};
    vecs[3]   = '{8'h3C, 10'b1_00111100_0, 1'b0};
    after_rst = '{8'hC3, 10'b1_11000011_0, 1'b0};

    // Reset with tx_valid high: reset must win.
    rst            = 1'b1;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'hEE;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_serial", 32'(tx_if.tx_serial), 32'd1);
      check("rst_ready", 32'(tx_if.tx_ready), 32'd1);
      check("rst_busy_done", 32'({tx_if.tx_busy, tx_if.tx_done}), 32'b00);
    end
    rst            = 1'b0;
    tx_if.tx_valid = 1'b0;
    @(negedge clk);
    check("post_rst_idle", 32'({tx_if.tx_ready, tx_if.tx_busy, tx_if.tx_serial}), 32'b101);
    rx_en = 1'b1;

    for (int i = 0; i < 4; i++) run_frame(vecs[i]);

    // Back-to-back with tx_valid held high.
    acc = 0; first_done = -1; second_done = -1; run = 0; gap = -1;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h00;
    for (int t = 0; t < 100; t++) begin
      if (acc == 1) tx_if.tx_data = 8'hFF;
      if (acc == 2) tx_if.tx_valid = 1'b0;
      if (tx_if.tx_valid && tx_if.tx_ready) begin
        acc++;
        exp_q.push_back(tx_if.tx_data);
      end
      if (tx_if.tx_done === 1'b1) begin
        if (first_done < 0) first_done = t;
        else second_done = t;
      end
      if (tx_if.tx_serial === 1'b1) begin
        run++;
      end else begin
        if (first_done >= 0 && gap < 0) gap = run;
        run = 0;
      end
      @(negedge clk);
    end
    check("b2b_accepts", 32'(acc), 32'd2);
    check("b2b_first_done", 32'(first_done), 32'd40);
    check("b2b_done_spacing", 32'(second_done - first_done), 32'd41);
    check("b2b_high_gap", 32'(gap), 32'd5);

    // Reset during data bit 3 of 0x55.
    rx_en          = 1'b0;
    d0             = done_cnt;
    tx_if.tx_valid = 1'b1;
    tx_if.tx_data  = 8'h55;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      if (c == 1) tx_if.tx_valid = 1'b0;
    end
    check("pre_abort_bit3", 32'(tx_if.tx_serial), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("abort_serial", 32'(tx_if.tx_serial), 32'd1);
    check("abort_busy_done", 32'({tx_if.tx_busy, tx_if.tx_done}), 32'b00);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_idle", 32'({tx_if.tx_ready, tx_if.tx_serial}), 32'b11);
    end
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    rx_en = 1'b1;
    run_frame(after_rst);

    // Loopback of every byte value.
    d0 = done_cnt;
    for (int w = 0; w < 256; w++) send_word(w[7:0]);
    waited = 0;
    while ((exp_q.size() != 0 || tx_if.tx_ready !== 1'b1) && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    check("loop_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check("loop_done_count", 32'(done_cnt - d0), 32'd256);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
